// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data_mem strobes, two-cycle load
// sequencing, MEM/WB register and the EX/MEM ALU forwarding path.
module mem_stage #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_regwrite,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              MEM_memread,
  output logic              MEM_memwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_fault
);

  typedef enum logic [1:0] {IDLE, ACTIVE, LOAD_WAIT} state_t;

  state_t              state;
  logic                l_memread, l_memwrite, l_regwrite;
  logic [DATA_W-1:0]   l_alu, l_store;
  logic [REG_W-1:0]    l_rd;
  logic                is_active, fault, do_load, accept;

  assign is_active = (state == ACTIVE);
  // Out-of-range address on a memory op, or a contradictory read+write.
  assign fault = ((l_memread | l_memwrite) & (|l_alu[DATA_W-1:ADDR_W]))
               | (l_memread & l_memwrite);
  assign do_load = is_active & l_memread & !fault;

  assign ex_ready     = !reset & !do_load;
  assign accept       = ex_valid & ex_ready;

  assign MEM_memread  = !reset & do_load;
  assign MEM_memwrite = !reset & is_active & l_memwrite & !fault;
  assign addr         = reset ? '0 : l_alu[ADDR_W-1:0];
  assign wdata        = reset ? '0 : l_store;

  assign fwd_valid    = !reset & is_active & l_regwrite & !l_memread & !fault;
  assign fwd_rd       = l_rd;
  assign fwd_data     = l_alu;
  assign mem_fault    = !reset & is_active & fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      l_memread   <= 1'b0;
      l_memwrite  <= 1'b0;
      l_regwrite  <= 1'b0;
      l_alu       <= '0;
      l_store     <= '0;
      l_rd        <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (is_active && !do_load) begin
        wb_valid    <= 1'b1;
        wb_rd       <= l_rd;
        wb_data     <= l_alu;
        wb_regwrite <= l_regwrite & !l_memwrite & !fault;
      end else if (state == LOAD_WAIT) begin
        wb_valid    <= 1'b1;
        wb_rd       <= l_rd;
        wb_data     <= rdata;
        wb_regwrite <= l_regwrite;
      end
      // Retirement above reads the old latched fields; a new op may
      // overwrite them at the same edge.
      if (do_load) begin
        state <= LOAD_WAIT;
      end else if (accept) begin
        state      <= ACTIVE;
        l_memread  <= ex_memread;
        l_memwrite <= ex_memwrite;
        l_regwrite <= ex_regwrite;
        l_alu      <= ex_alu_result;
        l_store    <= ex_store_data;
        l_rd       <= ex_rd;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
